ifetch_ir: RTL and testbench
============================

IFETCH_IR -- requirements
Module: ifetch_ir

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYC, default 16, SHALL be the fetch-wait limit in cycles (used only under REQ-032).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 fetch_start  input  1  SHALL be the fetch command pulse from the control FSM.
REQ-006 flush  input  1  SHALL abort an outstanding fetch.
REQ-007 pc_we  input  1  SHALL enable writing pc_next into the PC.
REQ-008 pc_next  input  32  SHALL be the next PC value.
REQ-009 mem_req  output  1  SHALL be the instruction-memory read request.
REQ-010 mem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-011 mem_rdata  input  32  SHALL be the instruction word, valid when mem_ready=1.
REQ-012 mem_ready  input  1  SHALL be the memory data-valid strobe.
REQ-013 ir_done  output  1  SHALL be a one-cycle pulse marking IR load.
REQ-014 busy  output  1  SHALL be high while a fetch is outstanding.
REQ-015 pc, pc_plus4  output  32 each  SHALL be the current PC and PC+4.
REQ-016 instr  output  32  SHALL be the IR contents.
REQ-017 opcode[6], rs[5], rt[5], rd[5], shamt[5], funct[6], imm16[16], jaddr[26]  outputs  SHALL be the IR fields [31:26],[25:21],[20:16],[15:11],[10:6],[5:0],[15:0],[25:0]; imm16 feeds the immediate extender.
REQ-018 fetch_err  output  1  SHALL be the sticky timeout flag (tied 0 without REQ-032).

Function
REQ-019 FSM SHALL have states IDLE and WAIT (plus ERR under REQ-032).
REQ-020 IDLE: on fetch_start=1 the block SHALL latch pc into the address register, assert mem_req and busy from the next cycle, and enter WAIT.
REQ-021 WAIT: mem_req SHALL stay high and mem_addr stable until mem_ready=1.
REQ-022 WAIT with mem_ready=1: the block SHALL load mem_rdata into the IR at that edge, pulse ir_done for exactly the following cycle, deassert mem_req/busy, and return to IDLE; latency from fetch_start SHALL be 1 cycle plus memory wait cycles plus 1 cycle.
REQ-023 fetch_start while in WAIT SHALL be ignored, with no queuing.
REQ-024 mem_ready while in IDLE SHALL be ignored and the IR left unchanged.
REQ-025 flush in WAIT SHALL return the FSM to IDLE next cycle without loading the IR or pulsing ir_done; flush with mem_ready in the same cycle SHALL give priority to flush.
REQ-026 flush together with fetch_start in IDLE SHALL leave the FSM in IDLE.
REQ-027 pc_we=1 SHALL load pc_next into the PC in any state; an in-flight fetch SHALL keep its latched address.
REQ-028 mem_addr SHALL be {addr[31:2],2'b00}, and pc_plus4 SHALL be pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-029 Field outputs SHALL be combinational from the IR and change only on IR load.

Reset
REQ-030 With rst_n=0 at a clock edge, the block SHALL set pc=RESET_PC, IR=0, FSM=IDLE, mem_req=0, busy=0, ir_done=0, and fetch_err=0, including when asserted mid-fetch (outstanding request dropped).
REQ-031 rst_n SHALL take priority over flush, fetch_start and pc_we.

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; on reaching TIMEOUT_CYC without mem_ready the block SHALL drop mem_req, load IR=32'h0000_0000 (NOP), set fetch_err (sticky until reset), pulse ir_done, and return to IDLE; without the macro there SHALL be no counter, WAIT is unbounded, and fetch_err=0.

Verification
REQ-033 Reset, then fetch_start with mem_ready=1 one cycle after mem_req, mem_rdata=32'h2008_FFFC -> mem_addr=0, ir_done one cycle, opcode=6'h08, rt=8, imm16=16'hFFFC.
REQ-034 Fetch with mem_ready delayed 5 cycles -> mem_req high 6 cycles, mem_addr stable, single ir_done; a second fetch_start mid-wait is ignored.
REQ-035 flush and mem_ready in the same WAIT cycle -> IR unchanged, no ir_done, FSM IDLE.
REQ-036 pc_we with pc_next=32'hFFFF_FFFC during WAIT -> mem_addr unchanged, pc=FFFF_FFFC, pc_plus4=0.
REQ-037 rst_n low mid-WAIT -> mem_req=0, pc=RESET_PC, and IR=0 next cycle.
REQ-038 With FETCH_TIMEOUT_EN and no mem_ready -> after 16 WAIT cycles IR=0, fetch_err=1, and ir_done pulses; without the macro mem_req stays high.

Source files
------------

// File: rtl/ifetch_ir.sv
// Instruction fetch unit: latches the PC into an address register, handshakes one word from
// instruction memory into the IR and decodes its fields. Optional fetch timeout: FETCH_TIMEOUT_EN.
module ifetch_ir #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        ir_done,
  output logic        busy,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        fetch_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_done_q, ir_done_d;
  logic        timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Fires on the last allowed WAIT cycle, so mem_req is high for exactly TIMEOUT_CYC cycles.
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == StWait) && (state_d == StWait)) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | ((state_q == StWait) && !flush && !mem_ready && timeout);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    ir_done_d = 1'b0;
    pc_d      = pc_we ? pc_next : pc_q;
    case (state_q)
      StIdle: begin
        // Fetch latches the PC as it stands before any same-cycle pc_we update.
        if (fetch_start && !flush) begin
          state_d = StWait;
          addr_d  = pc_q;
        end
      end
      StWait: begin
        if (flush) begin
          state_d = StIdle;
        end else if (mem_ready) begin
          state_d   = StIdle;
          ir_d      = mem_rdata;
          ir_done_d = 1'b1;
        end else if (timeout) begin
          state_d   = StIdle;
          ir_d      = 32'h0000_0000;
          ir_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      ir_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      ir_done_q <= ir_done_d;
    end
  end

  assign mem_req  = (state_q == StWait);
  assign busy     = (state_q == StWait);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign ir_done  = ir_done_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign instr    = ir_q;
  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign jaddr    = ir_q[25:0];

endmodule

// File: tb/tb_ifetch_ir.sv
// Bench for ifetch_ir: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a transaction-level model of the fetch unit.
module tb_ifetch_ir;

  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam int          TimeoutN = 16;
`ifdef FETCH_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, fetch_start, flush, pc_we, mem_ready;
  logic [31:0] pc_next, mem_rdata;
  logic        mem_req, ir_done, busy, fetch_err;
  logic [31:0] mem_addr, pc, pc_plus4, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  int checks   = 0;
  int failures = 0;

  // Model: "is a fetch outstanding", its address, how long it has waited, the IR and flags.
  bit          m_busy, m_done, m_err;
  int          m_wait;
  logic [31:0] m_pc, m_addr, m_ir;

  ifetch_ir #(
    .RESET_PC    (ResetPc),
    .TIMEOUT_CYC (TimeoutN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_start (fetch_start),
    .flush       (flush),
    .pc_we       (pc_we),
    .pc_next     (pc_next),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .ir_done     (ir_done),
    .busy        (busy),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .jaddr       (jaddr),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs to the model, as the DUT will see them at the next rising edge.
  task automatic model_step(input logic rstn, st, fl, we, input logic [31:0] nxt,
                            input logic rdy, input logic [31:0] rdat);
    bit done_n;
    if (!rstn) begin
      m_pc = ResetPc; m_ir = 32'h0; m_busy = 0; m_done = 0; m_err = 0; m_wait = 0;
      m_addr = ResetPc;
    end else begin
      done_n = 0;
      if (m_busy) begin
        if (fl) begin
          m_busy = 0;
        end else if (rdy) begin
          m_ir = rdat; done_n = 1; m_busy = 0;
        end else if (ToEn && (m_wait + 1 >= TimeoutN)) begin
          m_ir = 32'h0; done_n = 1; m_busy = 0; m_err = 1;
        end else begin
          m_wait++;
        end
      end else if (st && !fl) begin
        m_busy = 1; m_addr = m_pc; m_wait = 0;
      end
      if (we) m_pc = nxt;
      m_done = done_n;
    end
  endtask

  task automatic tick(input logic rstn, st, fl, we, input logic [31:0] nxt,
                      input logic rdy, input logic [31:0] rdat);
    rst_n = rstn; fetch_start = st; flush = fl; pc_we = we; pc_next = nxt;
    mem_ready = rdy; mem_rdata = rdat;
    model_step(rstn, st, fl, we, nxt, rdy, rdat);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_tick();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Single compare process: checks every output against the model shortly after each edge.
  always @(posedge clk) begin
    #2;
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("ir_done", {31'b0, ir_done}, {31'b0, m_done});
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr", instr, m_ir);
    chk("opcode", {26'b0, opcode}, m_ir >> 26);
    chk("rs", {27'b0, rs}, (m_ir >> 21) & 32'h1f);
    chk("rt", {27'b0, rt}, (m_ir >> 16) & 32'h1f);
    chk("rd", {27'b0, rd}, (m_ir >> 11) & 32'h1f);
    chk("shamt", {27'b0, shamt}, (m_ir >> 6) & 32'h1f);
    chk("funct", {26'b0, funct}, m_ir & 32'h3f);
    chk("imm16", {16'b0, imm16}, m_ir & 32'hffff);
    chk("jaddr", {6'b0, jaddr}, m_ir & 32'h03ff_ffff);
    if (m_busy) chk("mem_addr", mem_addr, m_addr & 32'hffff_fffc);
  end

  initial begin
    int req_cnt;
    int done_cnt;

    // Reset
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'hffff_ffff);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    // Basic fetch, one memory wait-free cycle
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("f1_req", {31'b0, mem_req}, 32'd1);
    chk("f1_addr", mem_addr, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_fffc);
    chk("f1_done", {31'b0, ir_done}, 32'd1);
    chk("f1_opcode", {26'b0, opcode}, 32'h08);
    chk("f1_rt", {27'b0, rt}, 32'd8);
    chk("f1_imm16", {16'b0, imm16}, 32'hfffc);
    chk("f1_req_low", {31'b0, mem_req}, 32'd0);
    idle_tick();
    chk("f1_done_once", {31'b0, ir_done}, 32'd0);

    // Delayed memory, extra fetch_start mid-wait, unaligned PC
    tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1003, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    req_cnt = mem_req ? 1 : 0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, (i == 2), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      if (mem_req) req_cnt++;
      if (ir_done) done_cnt++;
      chk("f2_addr", mem_addr, 32'h0000_1000);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0123_4567);
    if (ir_done) done_cnt++;
    chk("f2_req_after", {31'b0, mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle_tick();
      if (mem_req) req_cnt++;
      if (ir_done) done_cnt++;
    end
    chk("f2_req_cycles", req_cnt, 32'd6);
    chk("f2_done_count", done_cnt, 32'd1);
    chk("f2_instr", instr, 32'h0123_4567);

    // Flush beats mem_ready; flush with fetch_start in idle stays idle
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hdead_beef);
    chk("fl_done", {31'b0, ir_done}, 32'd0);
    chk("fl_instr", instr, 32'h0123_4567);
    chk("fl_busy", {31'b0, busy}, 32'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fl_start_idle", {31'b0, mem_req}, 32'd0);

    // PC write during WAIT, pc_plus4 wrap
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 32'hffff_fffc, 1'b0, 32'h0);
    chk("we_addr", mem_addr, 32'h0000_1000);
    chk("we_pc", pc, 32'hffff_fffc);
    chk("we_plus4", pc_plus4, 32'h0);
    chk("we_req", {31'b0, mem_req}, 32'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0c00_0010);
    chk("j_opcode", {26'b0, opcode}, 32'h03);
    chk("j_jaddr", {6'b0, jaddr}, 32'h10);

    // mem_ready in idle is ignored
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'haaaa_5555);
    chk("idle_ready", instr, 32'h0c00_0010);

    // Reset mid-WAIT
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_0000, 1'b0, 32'h0);
    chk("mrst_req", {31'b0, mem_req}, 32'd0);
    chk("mrst_pc", pc, ResetPc);
    chk("mrst_instr", instr, 32'h0);

    // Memory never answers
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    req_cnt = mem_req ? 1 : 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle_tick();
      if (mem_req) req_cnt++;
      if (ir_done) done_cnt++;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("to_req_cycles", req_cnt, 32'd16);
    chk("to_done_count", done_cnt, 32'd1);
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_instr", instr, 32'h0);
`else
    chk("nto_req_cycles", req_cnt, 32'd21);
    chk("nto_req_high", {31'b0, mem_req}, 32'd1);
    chk("nto_err", {31'b0, fetch_err}, 32'd0);
    chk("nto_instr", instr, 32'h1234_5678);
`endif
    tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(63) != 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0),
           ($urandom_range(5) == 0), $urandom, ($urandom_range(3) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
